// File: rtl/hash160_pkg.sv
// hash160_pkg: shared RIPEMD-160 constants, sequencer states and byte-swap helper
package hash160_pkg;
  localparam logic [31:0] H0 = 32'h67452301;
  localparam logic [31:0] H1 = 32'hefcdab89;
  localparam logic [31:0] H2 = 32'h98badcfe;
  localparam logic [31:0] H3 = 32'h10325476;
  localparam logic [31:0] H4 = 32'hc3d2e1f0;
  localparam int CORE_LAT_DEF = 81;
  localparam logic [31:0] PAD_WORD = 32'h00000080;
  localparam logic [31:0] LEN_WORD = 32'h00000100;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMBINE, RESULT} state_e;
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/ripemd160_pad.sv
// ripemd160_pad: builds the 512-bit core block from a 32-byte message or passes a raw block through
module ripemd160_pad
  import hash160_pkg::*;
(
  input  logic [255:0] msg_i,
  input  logic         raw_i,
  input  logic [511:0] block_i,
  output logic [511:0] block_o
);
  logic [511:0] pad;
  // message bytes are big-endian in msg_i, core words are little-endian
  always_comb begin
    pad = '0;
    for (int j = 0; j < 8; j++) pad[32*j +: 32] = bswap32(msg_i[255-32*j -: 32]);
    pad[32*8 +: 32] = PAD_WORD;
    pad[32*14 +: 32] = LEN_WORD;
  end
  assign block_o = raw_i ? block_i : pad;
endmodule

// File: rtl/ripemd160_ctrl.sv
// ripemd160_ctrl: launches both RIPEMD-160 line cores, captures them at a fixed latency and combines the digest
module ripemd160_ctrl
  import hash160_pkg::*;
#(
  parameter int CORE_LAT = CORE_LAT_DEF,
  parameter int CNT_W    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_raw,
  input  logic [255:0] i_msg,
  input  logic [511:0] i_block,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [159:0] o_digest,
  output logic         o_err,
  output logic         core_valid,
  output logic [511:0] core_block,
  input  logic         l_valid,
  input  logic [159:0] l_ans,
  input  logic         r_valid,
  input  logic [159:0] r_ans
);
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [159:0] l_q, r_q, digest_d;
  logic [511:0] block_d;
  logic [31:0] la, lb, lc, ld, le, ra, rb, rc, rd, re;
  ripemd160_pad u_pad (
    .msg_i   (i_msg),
    .raw_i   (i_raw),
    .block_i (i_block),
    .block_o (block_d)
  );
  assign o_ready = state_q == IDLE;
  assign {la, lb, lc, ld, le} = l_q;
  assign {ra, rb, rc, rd, re} = r_q;
  // final combine rotates the lanes by one word relative to the IV
  assign digest_d = {bswap32(H1 + lc + rd), bswap32(H2 + ld + re), bswap32(H3 + le + ra),
                     bswap32(H4 + la + rb), bswap32(H0 + lb + rc)};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      core_valid <= 1'b0;
      core_block <= '0;
      o_valid    <= 1'b0;
      o_digest   <= '0;
      o_err      <= 1'b0;
    end else begin
      core_valid <= 1'b0;
      case (state_q)
        IDLE: if (i_valid) begin
          core_block <= block_d;
          core_valid <= 1'b1;
          cnt_q      <= '0;
          state_q    <= LAUNCH;
        end
        LAUNCH: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(CORE_LAT)) begin
            l_q     <= l_ans;
            r_q     <= r_ans;
            o_err   <= o_err | ~(l_valid & r_valid);
            state_q <= COMBINE;
          end
        end
        COMBINE: begin
          o_digest <= digest_d;
          o_valid  <= 1'b1;
          state_q  <= RESULT;
        end
        RESULT: if (i_ready) begin
          o_valid <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ripemd160_ctrl.sv
// tb_ripemd160_ctrl: scoreboard bench with behavioural RIPEMD-160 line cores around the sequencer
module tb_ripemd160_ctrl;
  logic clk = 0, rst_n;
  logic i_valid, o_ready, i_raw, o_valid, i_ready, o_err, core_valid;
  logic l_valid, r_valid;
  logic [255:0] i_msg;
  logic [511:0] i_block, core_block;
  logic [159:0] o_digest, l_ans, r_ans;
  int checks = 0, errors = 0, cyc = 0;

  ripemd160_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_raw(i_raw),
    .i_msg(i_msg), .i_block(i_block), .o_valid(o_valid), .i_ready(i_ready),
    .o_digest(o_digest), .o_err(o_err), .core_valid(core_valid), .core_block(core_block),
    .l_valid(l_valid), .l_ans(l_ans), .r_valid(r_valid), .r_ans(r_ans)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int RL [80] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,
    7,4,13,1,10,6,15,3,12,0,9,5,2,14,11,8, 3,10,14,4,9,15,8,1,2,7,0,6,13,11,5,12,
    1,9,11,10,0,8,12,4,13,3,7,15,14,5,6,2, 4,0,5,9,7,12,2,10,14,1,3,8,11,6,15,13};
  localparam int RR [80] = '{5,14,7,0,9,2,11,4,13,6,15,8,1,10,3,12,
    6,11,3,7,0,13,5,10,14,15,8,12,4,9,1,2, 15,5,1,3,7,14,6,9,11,8,12,2,10,0,4,13,
    8,6,4,1,3,11,15,0,5,12,2,13,9,7,10,14, 12,15,10,4,1,5,8,7,6,2,13,14,0,3,9,11};
  localparam int SL [80] = '{11,14,15,12,5,8,7,9,11,13,14,15,6,7,9,8,
    7,6,8,13,11,9,7,15,7,12,15,9,11,7,13,12, 11,13,6,7,14,9,13,15,14,8,13,6,5,12,7,5,
    11,12,14,15,14,15,9,8,9,14,5,6,8,6,5,12, 9,15,5,11,6,8,13,12,5,12,13,14,11,8,5,6};
  localparam int SR [80] = '{8,9,9,11,13,15,15,5,7,7,8,11,14,14,12,6,
    9,13,15,7,12,8,9,11,7,7,12,7,6,15,13,11, 9,7,15,11,8,6,6,14,12,13,5,14,13,13,7,5,
    15,5,8,11,14,14,6,14,6,9,12,9,12,5,15,8, 8,5,12,9,12,5,14,6,8,13,6,5,15,13,11,11};
  localparam logic [31:0] KL [5] = '{32'h0, 32'h5a827999, 32'h6ed9eba1, 32'h8f1bbcdc, 32'ha953fd4e};
  localparam logic [31:0] KR [5] = '{32'h50a28be6, 32'h5c4dd124, 32'h6d703ef3, 32'h7a6d76e9, 32'h0};

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] bs(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // one full line of RIPEMD-160, returning the raw {A,B,C,D,E}
  function automatic logic [159:0] line(input logic [511:0] blk, input bit rt);
    logic [31:0] a, b, c, d, e, t, f, k;
    int j2, w, s;
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476; e = 32'hc3d2e1f0;
    for (int j = 0; j < 80; j++) begin
      j2 = rt ? 79 - j : j;
      case (j2 / 16)
        0: f = b ^ c ^ d;
        1: f = (b & c) | (~b & d);
        2: f = (b | ~c) ^ d;
        3: f = (b & d) | (c & ~d);
        default: f = b ^ (c | ~d);
      endcase
      k = rt ? KR[j/16] : KL[j/16];
      w = rt ? RR[j] : RL[j];
      s = rt ? SR[j] : SL[j];
      t = rol(a + f + blk[32*w +: 32] + k, s) + e;
      a = e; e = d; d = rol(c, 10); c = b; b = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [159:0] golden(input logic [511:0] blk);
    logic [159:0] l, r;
    l = line(blk, 1'b0);
    r = line(blk, 1'b1);
    return {bs(32'hefcdab89 + l[95:64] + r[63:32]), bs(32'h98badcfe + l[63:32] + r[31:0]),
            bs(32'h10325476 + l[31:0] + r[159:128]), bs(32'hc3d2e1f0 + l[159:128] + r[127:96]),
            bs(32'h67452301 + l[127:96] + r[95:64])};
  endfunction

  // behavioural cores: answer is correct only in launch cycle + 81
  int kc;
  bit l_fault;
  logic [159:0] lg, rg;
  always @(posedge clk) begin
    if (!rst_n) kc <= 0;
    else if (core_valid) begin
      kc <= 1;
      lg <= line(core_block, 1'b0);
      rg <= line(core_block, 1'b1);
    end else if (kc != 0 && kc < 200) kc <= kc + 1;
  end
  assign l_valid = kc >= 81 && !l_fault;
  assign r_valid = kc >= 81;
  assign l_ans = kc == 81 ? lg : ~lg;
  assign r_ans = kc == 81 ? rg : ~rg;

  typedef struct { logic [159:0] dig; logic err; int cyc; } exp_t;
  exp_t q[$];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  logic prev_ov = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_ov = 0;
    else begin
      if (o_valid && !prev_ov) begin
        if (q.size() == 0) check("spurious_valid", 1, 0);
        else check("valid_latency", cyc, q[0].cyc);
      end
      if (o_valid && i_ready && q.size() != 0) begin
        check("digest", o_digest, q[0].dig);
        check("err_flag", o_err, q[0].err);
        void'(q.pop_front());
      end
      prev_ov = o_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit raw, input logic [255:0] msg, input logic [511:0] blk,
                      input logic [511:0] exp_blk, input logic [159:0] dig, input bit err);
    int n = 0;
    exp_t e;
    i_valid = 1; i_raw = raw; i_msg = msg; i_block = blk;
    while (!o_ready && n < 400) begin tick(); n++; end
    check("accept", o_ready, 1);
    e.dig = dig; e.err = err; e.cyc = cyc + 84;
    q.push_back(e);
    tick();
    i_valid = 0;
    check("core_valid", core_valid, 1);
    check("core_block", core_block, exp_blk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin tick(); n++; end
    check("done_timeout", q.size(), 0);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_o_valid"}, o_valid, 0);
    check({tag, "_o_digest"}, o_digest, 0);
    check({tag, "_o_err"}, o_err, 0);
    check({tag, "_core_valid"}, core_valid, 0);
    check({tag, "_core_block"}, core_block, 0);
    check({tag, "_o_ready"}, o_ready, 1);
  endtask

  localparam logic [511:0] EMPTY = 512'h80;
  localparam logic [511:0] ABC = (512'h18 << 448) | 512'h80636261;
  localparam logic [511:0] PADX = (512'h100 << 448) | (512'h80 << 256) | (512'h01000000 << 224);
  localparam logic [159:0] D_EMPTY = 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31;
  localparam logic [159:0] D_ABC = 160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc;

  initial begin
    rst_n = 0; i_valid = 0; i_raw = 0; i_msg = '0; i_block = '0; i_ready = 1; l_fault = 0;
    repeat (3) tick();
    reset_vals("rst");
    rst_n = 1;
    tick();
    send(1, '0, EMPTY, EMPTY, D_EMPTY, 0);
    wait_done();
    send(1, '0, ABC, ABC, D_ABC, 0);
    send(1, '0, EMPTY, EMPTY, D_EMPTY, 0);
    wait_done();
    send(0, 256'h1, '1, PADX, golden(PADX), 0);
    wait_done();
    // backpressure with ignored input requests
    i_ready = 0;
    send(1, '0, ABC, ABC, D_ABC, 0);
    for (int n = 0; n < 200 && !o_valid; n++) tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", o_valid, 1);
      check("bp_digest", o_digest, D_ABC);
      check("bp_ready", o_ready, 0);
      i_valid = i[0]; i_raw = 1; i_block = EMPTY;
      tick();
    end
    i_valid = 0; i_ready = 1;
    tick();
    check("bp_release_ready", o_ready, 1);
    check("bp_release_valid", o_valid, 0);
    wait_done();
    // reset while waiting on the cores
    send(1, '0, ABC, ABC, D_ABC, 0);
    repeat (40) tick();
    rst_n = 0;
    q.delete();
    tick();
    reset_vals("midrst");
    rst_n = 1;
    tick();
    send(1, '0, ABC, ABC, D_ABC, 0);
    wait_done();
    // left core reports not-done at capture
    l_fault = 1;
    send(1, '0, ABC, ABC, D_ABC, 1);
    wait_done();
    l_fault = 0;
    send(1, '0, EMPTY, EMPTY, D_EMPTY, 1);
    wait_done();
    check("err_sticky", o_err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d want=finish", cyc);
    $fatal(1);
  end
endmodule
